cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit magnitude comparator (`comparator_struc`, outputs G/E/L) among NREQ requesters.
- Each requester presents an X/Y operand pair with a valid/ready handshake.
- The block grants one requester, latches its operands into the comparator, registers the G/E/L result tagged with the requester id, and holds it until the consumer accepts it.
- Sits between operand-producing blocks (code converter, arithmetic block) and any logic that consumes comparison outcomes.

Parameters:
- NREQ, 4, number of requesters; legal range 2..2**IDW.
- IDW, 2, width of the requester id tag.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  per-requester operand-pair valid.
- req_x  input  4*NREQ  X operands; requester i uses bits [4i+3:4i], bit 3 = X3 (MSB).
- req_y  input  4*NREQ  Y operands; same packing as req_x.
- req_ready  output  NREQ  one-hot grant/accept strobe.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_id  output  IDW  index of the requester that owns the result.
- res_g  output  1  X>Y.
- res_e  output  1  X=Y.
- res_l  output  1  X<Y.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE, rr_ptr=0, all operand/result registers 0.
  - res_valid=0, res_id=0, res_g=res_e=res_l=0, busy=0.
  - req_ready is 0 while rst is high.
- Reset mid-operation aborts any in-flight or held result; it is discarded with no handshake.
- FSM states: IDLE, CMP, RESP.
  - IDLE: if any req_valid is set, req_ready is driven combinationally, one-hot, to the winner w. Arbitration is round-robin: scan from index rr_ptr upward, wrap modulo NREQ, first set req_valid wins. On that edge:
    - latch x_reg=req_x[w] and y_reg=req_y[w], id_reg=w;
    - set rr_ptr=(w+1) mod NREQ;
    - go to CMP.
    - If no req_valid is set, stay in IDLE with req_ready=0.
  - CMP: the comparator sees x_reg/y_reg. On the edge:
    - register G/E/L into res_g/res_e/res_l and id_reg into res_id;
    - set res_valid=1;
    - go to RESP.
    - req_ready=0.
  - RESP: res_valid=1, and res_id/res_g/res_e/res_l are held stable. On the edge where res_ready=1:
    - clear res_valid;
    - go to IDLE.
    - req_ready=0 throughout RESP.
- Latency:
  - Accept at edge N gives res_valid=1 after edge N+1.
  - If res_ready is held high, the earliest next accept is at edge N+3 (one IDLE cycle).
  - Peak throughput is one compare per 3 cycles.
- Invariants:
  - When res_valid=1, exactly one of res_g/res_e/res_l is 1.
  - When res_valid=0, all three are 0.
  - req_ready is never asserted for a requester whose req_valid is 0.
- Requester rules:
  - Once req_valid[i] is raised, it is held with stable operands until req_ready[i].
  - A requester may drop req_valid only after being accepted.
- Simultaneous requests:
  - Only one is accepted per IDLE cycle; the rest wait.
  - Round-robin guarantees each waiting requester is served within NREQ grants.
- res_ready asserted while res_valid=0 is ignored.
- Comparison is unsigned 4-bit.

Test Plan:
- Reset then idle: rst high 2 cycles, no requests -> req_ready=0, res_valid=0, busy=0, all result bits 0.
- Single request: req 0 with X=4'b0001, Y=4'b1000, res_ready=1 -> req_ready=4'b0001 in cycle 0; res_valid=1 in cycle 2 with res_l=1, res_id=0; back in IDLE next cycle.
- Equal and greater:
  - req 2 with X=0011, Y=0011 -> res_e=1, res_id=2.
  - req 2 with X=0101, Y=0001 -> res_g=1.
- Fairness: all 4 req_valid high continuously, res_ready=1 -> grant order 0,1,2,3,0; each grant 3 cycles apart; no requester granted twice before all others are granted once.
- Backpressure: res_ready=0 for 5 cycles after result X=1001, Y=0001 on req 1 -> res_valid stays 1, res_g=1 and res_id=1 stable; no req_ready pulses; release res_ready -> res_valid=0 next cycle.
- Reset mid-operation: rst asserted in CMP state -> res_valid never rises; after release, rr_ptr=0 and a request on req 3 alone is granted normally.

Source files
------------

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter/sequencer sharing one 4-bit magnitude
// comparator among NREQ requesters. Accept -> compare -> hold result until
// the consumer takes it, then back to idle (one compare per 3 cycles peak).

// Structural 4-bit unsigned magnitude comparator built from per-bit slices.
module comparator_struc (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic       g_o,
  output logic       e_o,
  output logic       l_o
);
  logic [3:0] eq, gt, lt;
  // pre[i] = all bits above i are equal; pre[4] is the empty prefix
  logic [4:0] pre;
  logic [3:0] g_term, l_term;

  assign pre[4] = 1'b1;

  genvar i;
  generate
    for (i = 3; i >= 0; i--) begin : g_bit
      assign eq[i]     = ~(x_i[i] ^ y_i[i]);
      assign gt[i]     = x_i[i] & ~y_i[i];
      assign lt[i]     = ~x_i[i] & y_i[i];
      assign pre[i]    = pre[i+1] & eq[i];
      // first differing bit from the MSB decides the outcome
      assign g_term[i] = pre[i+1] & gt[i];
      assign l_term[i] = pre[i+1] & lt[i];
    end
  endgenerate

  assign g_o = |g_term;
  assign l_o = |l_term;
  assign e_o = pre[0];
endmodule

module cmp_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_x,
  input  logic [4*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic              res_g,
  output logic              res_e,
  output logic              res_l,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [3:0]     x_q, y_q;
  logic [IDW-1:0] id_q;
  logic           res_valid_q, res_g_q, res_e_q, res_l_q;
  logic [IDW-1:0] res_id_q;

  // arbitration results
  logic [NREQ-1:0] grant_oh;
  logic            any_req;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  rr_ptr_d;
  logic [3:0]      x_sel, y_sel;
  int unsigned     scan_idx;

  // comparator outputs
  logic cmp_g, cmp_e, cmp_l;

  // Round-robin scan: start at rr_ptr, wrap modulo NREQ, first valid wins.
  always_comb begin
    grant_oh = '0;
    any_req  = 1'b0;
    win_id   = '0;
    x_sel    = '0;
    y_sel    = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!any_req && req_valid[scan_idx]) begin
        any_req            = 1'b1;
        grant_oh[scan_idx] = 1'b1;
        win_id             = IDW'(scan_idx);
        x_sel              = req_x[4*scan_idx +: 4];
        y_sel              = req_y[4*scan_idx +: 4];
      end
    end
  end

  // Pointer moves just past the winner; explicit wrap covers NREQ < 2**IDW.
  always_comb begin
    rr_ptr_d = win_id + 1'b1;
    if (win_id == IDW'(NREQ - 1)) rr_ptr_d = '0;
  end

  comparator_struc u_cmp (
    .x_i (x_q),
    .y_i (y_q),
    .g_o (cmp_g),
    .e_o (cmp_e),
    .l_o (cmp_l)
  );

  // Sequencer: accept in IDLE, capture compare in CMP, hold result in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_g_q     <= 1'b0;
      res_e_q     <= 1'b0;
      res_l_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            x_q      <= x_sel;
            y_q      <= y_sel;
            id_q     <= win_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= CMP;
          end
        end
        CMP: begin
          res_g_q     <= cmp_g;
          res_e_q     <= cmp_e;
          res_l_q     <= cmp_l;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // flags are cleared with valid so G/E/L read all-zero when idle
          if (res_ready) begin
            res_valid_q <= 1'b0;
            res_g_q     <= 1'b0;
            res_e_q     <= 1'b0;
            res_l_q     <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant strobe is combinational so a request is taken the cycle it is seen.
  assign req_ready = (state_q == IDLE && !rst) ? grant_oh : '0;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_g     = res_g_q;
  assign res_e     = res_e_q;
  assign res_l     = res_l_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: inputs driven on the falling edge,
// outputs sampled 1ns later, expected values written by hand.
module tb_cmp_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_x, req_y;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid, res_ready;
  logic [IDW-1:0]    res_id;
  logic              res_g, res_e, res_l, busy;

  int n_chk  = 0;
  int n_pass = 0;

  cmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_g     (res_g),
    .res_e     (res_e),
    .res_l     (res_l),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
  endtask

  // One request with res_ready held high; gel = {G,E,L} expected.
  task automatic run_req(input int id, input logic [3:0] x, input logic [3:0] y,
                         input logic [2:0] gel);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    @(negedge clk);
    req_valid = oh;
    req_x[4*id +: 4] = x;
    req_y[4*id +: 4] = y;
    res_ready = 1'b1;
    #1 chk("grant", req_ready, oh);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    req_valid = '0;
    #1 chk("cmp_busy", busy, 1);
    chk("cmp_rv", res_valid, 0);
    chk("cmp_rdy", req_ready, 0);
    @(negedge clk);
    #1 chk("resp_rv", res_valid, 1);
    chk("resp_gel", {res_g, res_e, res_l}, gel);
    chk("resp_id", res_id, id);
    @(negedge clk);
    #1 chk("done_rv", res_valid, 0);
    chk("done_gel", {res_g, res_e, res_l}, 0);
    chk("done_busy", busy, 0);
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [NREQ-1:0] exp_rdy;
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; res_ready = 1'b0;

    // reset, with requests pending: no grant while rst is high
    @(negedge clk);
    req_valid = 4'b1111;
    #1 chk("rst_rdy", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    #1 chk("rst_rv", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gel", {res_g, res_e, res_l}, 0);
    chk("rst_id", res_id, 0);
    @(negedge clk);
    #1 chk("idle_rdy", req_ready, 0);
    chk("idle_busy", busy, 0);

    // single requests: less, equal, greater
    run_req(0, 4'b0001, 4'b1000, 3'b001);
    run_req(2, 4'b0011, 4'b0011, 3'b010);
    run_req(2, 4'b0101, 4'b0001, 3'b100);

    // reset while in CMP: result must never appear
    @(negedge clk);
    req_valid = 4'b0100;
    req_x[11:8] = 4'd7; req_y[11:8] = 4'd2;
    #1 chk("mid_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b1111;
    rst = 1'b1;
    #1 chk("mid_busy", busy, 1);
    chk("mid_rdy_rst", req_ready, 0);
    @(negedge clk);
    #1 chk("mid_rv", res_valid, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_rdy_rst2", req_ready, 0);

    // fairness from a reset pointer: grants 0,1,2,3,0 three cycles apart
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c != 0) @(negedge clk);
      exp_rdy = '0;
      if (c % 3 == 0) exp_rdy[order[c/3]] = 1'b1;
      #1 chk("fair_rdy", req_ready, exp_rdy);
      if (c % 3 == 2) begin
        chk("fair_rv", res_valid, 1);
        chk("fair_id", res_id, order[c/3]);
      end
    end
    req_valid = '0;

    // backpressure on requester 1 with requester 0 waiting
    @(negedge clk);
    req_valid = 4'b0010;
    req_x[7:4] = 4'b1001; req_y[7:4] = 4'b0001;
    req_x[3:0] = 4'd6;    req_y[3:0] = 4'd6;
    res_ready = 1'b0;
    #1 chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b0001;
    #1 chk("bp_cmp_rdy", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 chk("bp_rv", res_valid, 1);
      chk("bp_gel", {res_g, res_e, res_l}, 3'b100);
      chk("bp_id", res_id, 1);
      chk("bp_rdy", req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_rel_rv", res_valid, 0);
    chk("bp_rel_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 chk("bp_r0_rv", res_valid, 1);
    chk("bp_r0_gel", {res_g, res_e, res_l}, 3'b010);
    chk("bp_r0_id", res_id, 0);
    @(negedge clk);
    #1 chk("bp_r0_done", res_valid, 0);

    // requester 3 alone after all of the above
    run_req(3, 4'b1110, 4'b1111, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
